sense_uart_bridge: RTL and testbench

Parametrised UART command front-end for sensor readout, plus LED heartbeat.
- Decodes command bytes from the UART receiver and snapshots one of N_CH sensor channels of W bits.
- Serialises multi-byte replies to the UART transmitter through a ready/enable handshake.
- Drives the board LEDs: a heartbeat and a host-settable pattern or live sensor value.
- Sits between the uart instance and the sensor logic at top level.

---
 rtl/sense_uart_bridge_if.sv | 30 +++
 rtl/sense_uart_bridge.sv | 181 ++++++++++++++++++
 tb/tb_sense_uart_bridge.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sense_uart_bridge_if.sv
// Bus bundle between the UART/sensor side and sense_uart_bridge.
//   rx_ready/rx_data       : received byte strobe and data (master -> bridge)
//   tx_ready               : transmitter idle (master -> bridge)
//   tx_data/tx_enable      : byte to send and one-cycle launch pulse (bridge -> master)
//   sensor_data            : N_CH packed samples of W bits, channel c at [c*W +: W]
//   led_out/busy/err       : LED drive, non-idle flag, error pulse (bridge -> master)
interface sense_uart_bridge_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 12
);
    logic                rx_ready;
    logic [7:0]          rx_data;
    logic                tx_ready;
    logic [7:0]          tx_data;
    logic                tx_enable;
    logic [N_CH*W-1:0]   sensor_data;
    logic [7:0]          led_out;
    logic                busy;
    logic                err;

    modport master (
        output rx_ready, rx_data, tx_ready, sensor_data,
        input  tx_data, tx_enable, led_out, busy, err
    );

    modport slave (
        input  rx_ready, rx_data, tx_ready, sensor_data,
        output tx_data, tx_enable, led_out, busy, err
    );
endinterface

// File: rtl/sense_uart_bridge.sv
// UART command front-end for sensor readout with LED heartbeat.
// Decodes command bytes (READ / STATUS / SET_LED), snapshots a sensor channel and
// serialises the reply through a ready/enable transmitter handshake.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : sense_uart_bridge_if slave modport (rx, tx, sensors, LEDs, busy, err)
module sense_uart_bridge #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned W         = 12,
    parameter int unsigned HB_PERIOD = 6000000,
    parameter int unsigned LED_MODE  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    sense_uart_bridge_if.slave  io_bus
);

    localparam int unsigned NB  = (W + 7) / 8;
    localparam int unsigned HBW = $clog2(HB_PERIOD);

    typedef enum logic [2:0] {
        StIdle,
        StArg,
        StLoad,
        StSend,
        StWaitLo,
        StWaitHi
    } state_e;

    state_e         r_state;
    state_e         w_next_state;
    logic [7:0]     r_cmd;
    logic [6:0]     r_pattern;
    logic [6:0]     r_last_top;
    logic           r_overrun;
    logic [2:0]     r_count;
    logic [39:0]    r_shift;
    logic [HBW-1:0] r_hb_cnt;
    logic           r_hb;

    logic [W-1:0]   w_sample;
    logic [6:0]     w_sample_top;
    logic [31:0]    w_data_aligned;
    logic           w_ch_valid;
    logic           w_read_ok;
    logic           w_bad;
    logic           w_drop;
    logic [39:0]    w_reply;
    logic [2:0]     w_reply_len;

    // Channel mux built as a loop so an out-of-range argument never indexes past the bus.
    always_comb begin
        w_sample = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (r_cmd[5:0] == 6'(c)) begin
                w_sample = io_bus.sensor_data[c*W +: W];
            end
        end
    end

    generate
        if (W >= 7) begin : g_top
            assign w_sample_top = w_sample[W-1 -: 7];
        end else begin : g_pad
            assign w_sample_top = 7'(w_sample);
        end
    endgenerate

    // Left-align the zero-extended sample so its top reply byte sits at [31:24].
    assign w_data_aligned = 32'(w_sample) << (8 * (4 - NB));
    assign w_ch_valid     = 32'(r_cmd[5:0]) < N_CH;
    assign w_read_ok      = (r_cmd[7:6] == 2'b00) && w_ch_valid;

    always_comb begin
        w_reply     = '0;
        w_reply_len = 3'd1;
        w_bad       = 1'b0;
        unique case (r_cmd[7:6])
            2'b00: begin
                if (w_ch_valid) begin
                    w_reply[39:32] = {2'b10, r_cmd[5:0]};
                    w_reply[31:0]  = w_data_aligned;
                    w_reply_len    = 3'(NB + 1);
                end else begin
                    w_reply[39:32] = 8'hEE;
                    w_bad          = 1'b1;
                end
            end
            2'b01: w_reply[39:32] = {r_overrun, 1'b0, 6'(N_CH)};
            2'b10: w_reply[39:32] = 8'hAA;
            2'b11: begin
                w_reply[39:32] = 8'hEE;
                w_bad          = 1'b1;
            end
            default: w_reply = '0;
        endcase
    end

    // A byte arriving while a reply is in flight cannot be queued.
    assign w_drop = io_bus.rx_ready && (r_state inside {StLoad, StSend, StWaitLo, StWaitHi});

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle: begin
                if (io_bus.rx_ready) begin
                    w_next_state = (io_bus.rx_data[7:6] == 2'b10) ? StArg : StLoad;
                end
            end
            StArg:    if (io_bus.rx_ready) w_next_state = StLoad;
            StLoad:   w_next_state = StSend;
            StSend:   if (io_bus.tx_ready) w_next_state = StWaitLo;
            StWaitLo: if (!io_bus.tx_ready) w_next_state = StWaitHi;
            StWaitHi: begin
                if (io_bus.tx_ready) begin
                    w_next_state = (r_count == 3'd1) ? StIdle : StSend;
                end
            end
            default:  w_next_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cmd      <= '0;
            r_pattern  <= '0;
            r_last_top <= '0;
            r_overrun  <= 1'b0;
            r_count    <= '0;
            r_shift    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == StIdle && io_bus.rx_ready) begin
                r_cmd <= io_bus.rx_data;
            end
            if (r_state == StArg && io_bus.rx_ready) begin
                r_pattern <= io_bus.rx_data[7:1];
            end
            if (r_state == StLoad) begin
                r_shift <= w_reply;
                r_count <= w_reply_len;
                if (w_read_ok) begin
                    r_last_top <= w_sample_top;
                end
            end else if (r_state == StWaitHi && io_bus.tx_ready) begin
                r_count <= r_count - 3'd1;
                // Keep the last byte on tx_data once the reply is done.
                if (r_count != 3'd1) begin
                    r_shift <= {r_shift[31:0], 8'h00};
                end
            end
            // Set has priority over the STATUS clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (r_state == StLoad && r_cmd[7:6] == 2'b01) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hb_cnt <= '0;
            r_hb     <= 1'b0;
        end else if (r_hb_cnt == HBW'(HB_PERIOD - 1)) begin
            r_hb_cnt <= '0;
            r_hb     <= ~r_hb;
        end else begin
            r_hb_cnt <= r_hb_cnt + HBW'(1);
        end
    end

    assign io_bus.tx_data   = r_shift[39:32];
    assign io_bus.tx_enable = (r_state == StSend) && io_bus.tx_ready;
    assign io_bus.busy      = (r_state != StIdle);
    assign io_bus.err       = w_drop || ((r_state == StLoad) && w_bad);
    assign io_bus.led_out   = {(LED_MODE == 1) ? r_last_top : r_pattern, r_hb};

endmodule

// File: tb/tb_sense_uart_bridge.sv
// Self-checking bench for sense_uart_bridge: two instances (pattern LEDs and sample LEDs)
// share stimulus; replies are checked against a byte-level command model.
module tb_sense_uart_bridge;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 12;
    localparam int unsigned HB   = 10;
    localparam int unsigned NB   = (W + 7) / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sense_uart_bridge_if #(.N_CH(N_CH), .W(W)) bus0 ();
    sense_uart_bridge_if #(.N_CH(N_CH), .W(W)) bus1 ();

    sense_uart_bridge #(.N_CH(N_CH), .W(W), .HB_PERIOD(HB), .LED_MODE(0)) dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus0)
    );

    sense_uart_bridge #(.N_CH(N_CH), .W(W), .HB_PERIOD(HB), .LED_MODE(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus1)
    );

    assign bus1.rx_ready    = bus0.rx_ready;
    assign bus1.rx_data     = bus0.rx_data;
    assign bus1.tx_ready    = bus0.tx_ready;
    assign bus1.sensor_data = bus0.sensor_data;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int err_cnt = 0;
    int first_en_cyc = -1;
    int last_rx_cyc = 0;
    logic [7:0] got_q[$];

    // Model state
    logic [6:0]        m_pat = '0;
    logic [W-1:0]      m_last = '0;
    bit                m_ovr = 1'b0;
    logic [N_CH*W-1:0] sens = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter side collector
    initial begin
        forever begin
            @(negedge clk);
            if (bus0.tx_enable === 1'b1) begin
                if (got_q.size() == 0) first_en_cyc = cyc;
                got_q.push_back(bus0.tx_data);
            end
            if (bus0.err === 1'b1) err_cnt++;
        end
    end

    // UART transmitter emulation: busy for a random time after each launch
    initial begin
        bus0.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus0.tx_enable === 1'b1) begin
                @(posedge clk);
                repeat ($urandom_range(0, 1)) @(posedge clk);
                #1 bus0.tx_ready = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 bus0.tx_ready = 1'b1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_cmd);
        @(posedge clk);
        #1;
        bus0.rx_data  = b;
        bus0.rx_ready = 1'b1;
        if (is_cmd) last_rx_cyc = cyc;
        @(posedge clk);
        #1 bus0.rx_ready = 1'b0;
    endtask

    task automatic transact(input logic [7:0] b0, input logic [7:0] b1, input bit drop,
                            input string tag);
        logic [7:0]   exp_q[$];
        int           exp_err;
        int           arg;
        logic [1:0]   op;
        logic [W-1:0] smp;
        bit           done;
        exp_err = 0;
        done    = 1'b0;
        op      = b0[7:6];
        arg     = int'(b0[5:0]);
        case (op)
            2'd0: begin
                if (arg < N_CH) begin
                    smp = sens[arg*W +: W];
                    exp_q.push_back(8'(128 + arg));
                    for (int k = NB - 1; k >= 0; k--) begin
                        exp_q.push_back(8'((32'(smp) >> (8 * k)) % 256));
                    end
                    m_last = smp;
                end else begin
                    exp_q.push_back(8'hEE);
                    exp_err++;
                end
            end
            2'd1: begin
                exp_q.push_back(8'((m_ovr ? 128 : 0) + N_CH));
                m_ovr = 1'b0;
            end
            2'd2: begin
                exp_q.push_back(8'hAA);
                m_pat = 7'(b1 / 2);
            end
            default: begin
                exp_q.push_back(8'hEE);
                exp_err++;
            end
        endcase
        if (drop) begin
            exp_err++;
            m_ovr = 1'b1;
        end

        got_q.delete();
        err_cnt      = 0;
        first_en_cyc = -1;
        send_byte(b0, 1'b1);
        if (op == 2'd2) send_byte(b1, 1'b1);
        if (drop) send_byte(8'($urandom), 1'b0);
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (bus0.busy === 1'b0) done = 1'b1;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        check({tag, "_err"}, 64'(err_cnt), 64'(exp_err));
        check({tag, "_latency"}, 64'(first_en_cyc - last_rx_cyc), 64'd2);
        check({tag, "_hold"}, 64'(bus0.tx_data), 64'(exp_q[exp_q.size() - 1]));
        check({tag, "_led_pat"}, 64'(bus0.led_out[7:1]), 64'(m_pat));
        check({tag, "_led_smp"}, 64'(bus1.led_out[7:1]), 64'(m_last / (2 ** (W - 7))));
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        bit         drop;
        bit         hit;
        int         n_en;
        bus0.rx_ready    = 1'b0;
        bus0.rx_data     = '0;
        sens             = {12'h123, 12'hABC, 12'h456, 12'h789};
        bus0.sensor_data = sens;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx_data", 64'(bus0.tx_data), 64'd0);
        check("rst_tx_enable", 64'(bus0.tx_enable), 64'd0);
        check("rst_busy", 64'(bus0.busy), 64'd0);
        check("rst_err", 64'(bus0.err), 64'd0);
        check("rst_led0", 64'(bus0.led_out), 64'd0);
        check("rst_led1", 64'(bus1.led_out), 64'd0);

        // Heartbeat toggles on the 10th and 20th cycle after release
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("hb_c9", 64'(bus0.led_out[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("hb_c10", 64'(bus0.led_out[0]), 64'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("hb_c19", 64'(bus0.led_out[0]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("hb_c20", 64'(bus0.led_out[0]), 64'd0);

        // Directed commands
        transact(8'h02, 8'h00, 1'b0, "read_ch2");
        transact(8'h05, 8'h00, 1'b0, "read_bad");
        transact(8'hC0, 8'h00, 1'b0, "reserved");
        transact(8'h80, 8'hA5, 1'b0, "set_led");
        check("set_led_const", 64'(bus0.led_out[7:1]), 64'h52);
        check("smp_led_const", 64'(bus1.led_out[7:1]), 64'h55);
        transact(8'h01, 8'h00, 1'b1, "read_drop");
        transact(8'h40, 8'h00, 1'b0, "status_ovr");
        transact(8'h40, 8'h00, 1'b0, "status_clr");

        // Randomised commands
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < N_CH; c++) sens[c*W +: W] = W'($urandom);
            bus0.sensor_data = sens;
            b0   = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
            b1   = 8'($urandom);
            drop = (b0[7:6] == 2'b00) && (b0[5:0] < 6'(N_CH)) && ($urandom_range(0, 3) == 0);
            transact(b0, b1, drop, $sformatf("rnd%0d", t));
        end

        // Reset while the second reply byte is being launched
        sens[2*W +: W]   = 12'hABC;
        bus0.sensor_data = sens;
        got_q.delete();
        send_byte(8'h02, 1'b1);
        hit  = 1'b0;
        n_en = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (bus0.tx_enable === 1'b1) n_en++;
            if (n_en == 2) hit = 1'b1;
        end
        check("mid_rst_reached", 64'(hit), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_enable", 64'(bus0.tx_enable), 64'd0);
        check("mid_rst_busy", 64'(bus0.busy), 64'd0);
        check("mid_rst_tx_data", 64'(bus0.tx_data), 64'd0);
        check("mid_rst_led", 64'(bus0.led_out), 64'd0);
        m_pat  = '0;
        m_last = '0;
        m_ovr  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check("post_rst_idle", 64'(bus0.busy), 64'd0);
        transact(8'h00, 8'h00, 1'b0, "post_rst_read0");
        transact(8'h40, 8'h00, 1'b0, "post_rst_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
